ram_dev: RTL and testbench
==========================

# ram_dev

Single-port, byte-addressed, big-endian RAM device that services the `if_dev_ram` request bundle (`op`, `size`, `addr`, `data_in`) driven by the program loader and, after load completes, by the CPU. It sits directly downstream of the loader: every `RAM_STORE` cycle the loader issues is committed here, and later `RAM_LOAD` requests return data on `data_out` one cycle later. Storage is an array of 64-bit quads; sub-quad accesses select byte lanes.

## Interface
- `DEPTH`, 1024: number of 64-bit quads; byte address space is `DEPTH*8`.
- `AW`, 32: width of `addr`.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `op` input `pkg_ram` op enum: `RAM_NOP`, `RAM_LOAD`, `RAM_STORE`.
- `size` input integer (`pkg_ram` size): `RAM_BYTE`=8, `RAM_WORD`=16, `RAM_LONG`=32, `RAM_QUAD`=64.
- `addr` input AW: byte address.
- `data_in` input 64: store data, right-aligned (low `size` bits used).
- `data_out` output 64: load result, zero-extended, right-aligned.
- `data_valid` output 1: `data_out` holds the result of the previous cycle's accepted load.
- `error` output 1: previous cycle's request was rejected.

## Operation
- Request sampled every rising edge; no handshake, no stall: one request per cycle, always accepted or rejected in that cycle.
- Quad index = `addr[AW-1:3]`; byte offset = `addr[2:0]`. Byte at offset 0 is the most significant byte of the quad (big-endian).
- Alignment rule: `addr` must be a multiple of `size/8`. Range rule: quad index < `DEPTH`.
- `RAM_STORE`, legal: write the low `size` bits of `data_in` into bytes `offset .. offset+size/8-1`, MSB first; other bytes of the quad unchanged. Example: LONG store of `0x68656C6C` at addr 4 sets bytes 4..7 to `68 65 6C 6C`.
- `RAM_LOAD`, legal: read the same byte range, right-align into `data_out`, upper bits zero; `data_valid`=1 next cycle.
- `RAM_NOP`: no memory effect; `data_valid`=0, `error`=0 next cycle; `data_out` holds its last value.
- Illegal (misaligned or out of range) LOAD/STORE: no memory write, `data_out` unchanged, `data_valid`=0, `error`=1 for one cycle.
- Unknown `op` or `size` encoding: treated as illegal.
- Memory contents are not reset and are not initialised; reading an unwritten location returns undefined data (bench must not check it).

## Timing
- Store: written at the edge that samples it; a LOAD in the very next cycle to an overlapping address returns the new bytes.
- Load latency: exactly 1 cycle; back-to-back loads produce back-to-back `data_valid` pulses.
- `data_valid` and `error` are registered single-cycle flags, mutually exclusive, recomputed every cycle.
- Reset (asynchronous assert, any time, including mid-load): `data_out`=0, `data_valid`=0, `error`=0 immediately. A load in flight is dropped. A store sampled at the same edge as reset deassertion is performed. Memory contents are preserved across reset.
- Loader pattern (STORE one cycle, NOP one cycle, `addr`+4) must commit every word, with no dependence on the NOP gap.

## Test plan
- Loader replay: LONG stores `0x10100020` @0, `0x20210000` @4, `0x68656C6C` @32; then LONG loads @0, @4, @32 -> `data_out` = `0x10100020`, `0x20210000`, `0x68656C6C`, each with `data_valid`=1 one cycle after request.
- Byte lanes: QUAD store `0x0011223344556677` @8; BYTE load @9 -> `0x11`; WORD load @12 -> `0x4455`; BYTE store `0xAB` @15, QUAD load @8 -> `0x00112233445566AB`.
- Alignment: LONG load @2 and WORD store @5 -> `error`=1, `data_valid`=0, no write (QUAD load @0 unchanged).
- Range: LONG store @`DEPTH*8` -> `error`=1; no aliasing into quad 0.
- Read-after-write: LONG store `0xDEADBEEF` @16 in cycle n, LONG load @16 in cycle n+1 -> `0xDEADBEEF` at n+2; consecutive loads @16,@20 -> valid on two consecutive cycles.
- Reset: assert `rst_n`=0 the cycle after a load -> `data_valid`, `error`, `data_out` go 0 immediately; after release, earlier stored data still reads back.

Source files
------------

// File: rtl/ram_dev.sv
// ram_dev: single-port, byte-addressed, big-endian RAM built from 64-bit quads.
// One request per cycle; loads return one cycle later on data_out, and a
// rejected request raises error for one cycle.
module ram_dev #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    op,
    input  logic [6:0]    size,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   data_in,
    output logic [63:0]   data_out,
    output logic          data_valid,
    output logic          error
);

    localparam logic [1:0] RAM_NOP   = 2'd0;
    localparam logic [1:0] RAM_LOAD  = 2'd1;
    localparam logic [1:0] RAM_STORE = 2'd2;

    localparam logic [6:0] RAM_BYTE = 7'd8;
    localparam logic [6:0] RAM_WORD = 7'd16;
    localparam logic [6:0] RAM_LONG = 7'd32;
    localparam logic [6:0] RAM_QUAD = 7'd64;

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0]   mem [DEPTH];

    logic          size_ok;
    logic [3:0]    nbytes;
    logic [7:0]    size_bytes;
    logic [63:0]   size_mask;
    logic [2:0]    align_mask;
    logic          aligned;
    logic          in_range;
    logic          legal;
    logic          do_load;
    logic          do_store;
    logic          reject;
    logic [2:0]    shb;
    logic [5:0]    shamt;
    logic [7:0]    byte_en;
    logic [63:0]   wr_data;
    logic [63:0]   rd_data;
    logic [IW-1:0] idx;

    // Decode size, check alignment/range and compute lane placement.
    always_comb begin
        size_ok    = 1'b1;
        nbytes     = 4'd0;
        size_bytes = 8'h00;
        size_mask  = 64'h0;
        case (size)
            RAM_BYTE: begin nbytes = 4'd1; size_bytes = 8'h01; size_mask = 64'hFF; end
            RAM_WORD: begin nbytes = 4'd2; size_bytes = 8'h03; size_mask = 64'hFFFF; end
            RAM_LONG: begin nbytes = 4'd4; size_bytes = 8'h0F; size_mask = 64'hFFFF_FFFF; end
            RAM_QUAD: begin nbytes = 4'd8; size_bytes = 8'hFF; size_mask = '1; end
            default:  size_ok = 1'b0;
        endcase

        align_mask = 3'(nbytes - 4'd1);
        aligned    = (addr[2:0] & align_mask) == 3'd0;
        in_range   = (addr >> 3) < AW'(DEPTH);
        legal      = size_ok && aligned && in_range;

        do_load  = (op == RAM_LOAD) && legal;
        do_store = (op == RAM_STORE) && legal;
        // Anything but a NOP that is not a legal load/store is rejected,
        // including the unused op encoding.
        reject   = (op != RAM_NOP) && !do_load && !do_store;

        // Big-endian: the last byte of the access sits (8-offset-nbytes) lanes
        // above bit 0 of the quad.
        shb     = 3'(4'd8 - {1'b0, addr[2:0]} - nbytes);
        shamt   = {shb, 3'b000};
        byte_en = size_bytes << shb;
        wr_data = (data_in & size_mask) << shamt;

        idx     = addr[IW+2:3];
        rd_data = (mem[idx] >> shamt) & size_mask;
    end

    // Byte-lane write; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Registered load result and single-cycle status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= 64'h0;
            data_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            data_valid <= do_load;
            error      <= reject;
            if (do_load) begin
                data_out <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_dev.sv
// tb_ram_dev: directed and randomized checks of ram_dev against a byte-array
// reference model.
module tb_ram_dev;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 32;

    localparam logic [1:0] RAM_NOP   = 2'd0;
    localparam logic [1:0] RAM_LOAD  = 2'd1;
    localparam logic [1:0] RAM_STORE = 2'd2;
    localparam logic [1:0] RAM_BAD   = 2'd3;

    localparam logic [6:0] RAM_BYTE = 7'd8;
    localparam logic [6:0] RAM_WORD = 7'd16;
    localparam logic [6:0] RAM_LONG = 7'd32;
    localparam logic [6:0] RAM_QUAD = 7'd64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    op;
    logic [6:0]    size;
    logic [AW-1:0] addr;
    logic [63:0]   data_in;
    logic [63:0]   data_out;
    logic          data_valid;
    logic          error;

    int total = 0;
    int bad   = 0;

    // Reference model: one entry per written byte address.
    logic [7:0]  ref_mem [int unsigned];
    logic [63:0] exp_out;
    logic        exp_valid;
    logic        exp_err;
    logic        exp_known;

    ram_dev #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .size       (size),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        exp_out   = 64'h0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_known = 1'b1;
    endtask

    // Apply one request across one clock edge, then update the model. Returns
    // 1 ns after the edge with op back at NOP.
    task automatic req(input logic [1:0] o, input logic [6:0] s, input logic [31:0] a,
                       input logic [63:0] d);
        int unsigned nb;
        logic        size_legal;
        logic        legal;
        logic [63:0] v;
        op = o; size = s; addr = a; data_in = d;
        @(posedge clk);
        #1;
        op = RAM_NOP;
        size_legal = (s == 7'd8) || (s == 7'd16) || (s == 7'd32) || (s == 7'd64);
        nb    = size_legal ? int'(s) / 8 : 1;
        legal = size_legal && (a % nb == 0) && (longint'(a) < longint'(DEPTH) * 8);
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (o == RAM_NOP) begin
            // nothing
        end else if (!legal || o == RAM_BAD) begin
            exp_err = 1'b1;
        end else if (o == RAM_STORE) begin
            for (int i = 0; i < int'(nb); i++)
                ref_mem[a + i] = d[8*(int'(nb)-1-i) +: 8];
        end else begin
            v = 64'h0;
            exp_known = 1'b1;
            for (int i = 0; i < int'(nb); i++) begin
                if (!ref_mem.exists(a + i)) exp_known = 1'b0;
                else v = (v << 8) | 64'(ref_mem[a + i]);
            end
            exp_out   = v;
            exp_valid = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; op = RAM_NOP; size = RAM_BYTE; addr = '0; data_in = '0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        total++;
        if ({data_valid, error, data_out} !== {1'b0, 1'b0, 64'h0}) begin
            bad++;
            $display("FAIL reset_state got v=%0b e=%0b d=%h want 0 0 0", data_valid, error, data_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_loader();
        req(RAM_STORE, RAM_LONG, 0, 64'h10100020);
        req(RAM_NOP,   RAM_LONG, 0, 64'h0);
        req(RAM_STORE, RAM_LONG, 4, 64'h20210000);
        req(RAM_NOP,   RAM_LONG, 4, 64'h0);
        req(RAM_STORE, RAM_LONG, 32, 64'h68656C6C);
        total++;
        if ({data_valid, error} !== 2'b00) begin
            bad++;
            $display("FAIL store_flags got v=%0b e=%0b want 0 0", data_valid, error);
        end
        req(RAM_LOAD, RAM_LONG, 0, 64'h0);
        total++;
        if ({data_valid, error, data_out} !== {2'b10, 64'h10100020}) begin
            bad++;
            $display("FAIL loader_ld0 got v=%0b e=%0b d=%h want 1 0 10100020", data_valid, error, data_out);
        end
        req(RAM_LOAD, RAM_LONG, 4, 64'h0);
        total++;
        if ({data_valid, error, data_out} !== {2'b10, 64'h20210000}) begin
            bad++;
            $display("FAIL loader_ld4 got v=%0b e=%0b d=%h want 1 0 20210000", data_valid, error, data_out);
        end
        req(RAM_LOAD, RAM_LONG, 32, 64'h0);
        total++;
        if ({data_valid, error, data_out} !== {2'b10, 64'h68656C6C}) begin
            bad++;
            $display("FAIL loader_ld32 got v=%0b e=%0b d=%h want 1 0 68656c6c", data_valid, error, data_out);
        end
        req(RAM_NOP, RAM_LONG, 0, 64'h0);
        total++;
        if ({data_valid, error, data_out} !== {2'b00, 64'h68656C6C}) begin
            bad++;
            $display("FAIL nop_hold got v=%0b e=%0b d=%h want 0 0 68656c6c", data_valid, error, data_out);
        end
    endtask

    task automatic test_byte_lanes();
        req(RAM_STORE, RAM_QUAD, 8, 64'h0011223344556677);
        req(RAM_LOAD, RAM_BYTE, 9, 64'h0);
        total++;
        if ({data_valid, data_out} !== {1'b1, 64'h11}) begin
            bad++;
            $display("FAIL byte_ld9 got v=%0b d=%h want 1 11", data_valid, data_out);
        end
        req(RAM_LOAD, RAM_WORD, 12, 64'h0);
        total++;
        if ({data_valid, data_out} !== {1'b1, 64'h4455}) begin
            bad++;
            $display("FAIL word_ld12 got v=%0b d=%h want 1 4455", data_valid, data_out);
        end
        req(RAM_STORE, RAM_BYTE, 15, 64'hFFFF_FFFF_FFFF_FFAB);
        req(RAM_LOAD, RAM_QUAD, 8, 64'h0);
        total++;
        if ({data_valid, data_out} !== {1'b1, 64'h00112233445566AB}) begin
            bad++;
            $display("FAIL quad_ld8 got v=%0b d=%h want 1 00112233445566ab", data_valid, data_out);
        end
    endtask

    task automatic test_alignment();
        req(RAM_LOAD, RAM_LONG, 2, 64'h0);
        total++;
        if ({data_valid, error, data_out} !== {2'b01, 64'h00112233445566AB}) begin
            bad++;
            $display("FAIL misalign_ld got v=%0b e=%0b d=%h want 0 1 held", data_valid, error, data_out);
        end
        req(RAM_STORE, RAM_WORD, 5, 64'hBEEF);
        total++;
        if ({data_valid, error} !== 2'b01) begin
            bad++;
            $display("FAIL misalign_st got v=%0b e=%0b want 0 1", data_valid, error);
        end
        req(RAM_LOAD, RAM_QUAD, 0, 64'h0);
        total++;
        if ({data_valid, error, data_out} !== {2'b10, 64'h1010002020210000}) begin
            bad++;
            $display("FAIL misalign_nowr got v=%0b e=%0b d=%h want 1 0 1010002020210000", data_valid, error, data_out);
        end
        req(RAM_BAD, RAM_LONG, 0, 64'h0);
        total++;
        if ({data_valid, error} !== 2'b01) begin
            bad++;
            $display("FAIL bad_op got v=%0b e=%0b want 0 1", data_valid, error);
        end
        req(RAM_LOAD, 7'd24, 0, 64'h0);
        total++;
        if ({data_valid, error} !== 2'b01) begin
            bad++;
            $display("FAIL bad_size got v=%0b e=%0b want 0 1", data_valid, error);
        end
    endtask

    task automatic test_range();
        req(RAM_STORE, RAM_LONG, DEPTH * 8, 64'hFFFF_FFFF);
        total++;
        if ({data_valid, error} !== 2'b01) begin
            bad++;
            $display("FAIL range_st got v=%0b e=%0b want 0 1", data_valid, error);
        end
        req(RAM_LOAD, RAM_QUAD, 0, 64'h0);
        total++;
        if (data_out !== 64'h1010002020210000) begin
            bad++;
            $display("FAIL range_alias got d=%h want 1010002020210000", data_out);
        end
        req(RAM_STORE, RAM_QUAD, DEPTH * 8 - 8, 64'hCAFE_F00D_1234_5678);
        req(RAM_LOAD, RAM_QUAD, DEPTH * 8 - 8, 64'h0);
        total++;
        if ({data_valid, error, data_out} !== {2'b10, 64'hCAFEF00D12345678}) begin
            bad++;
            $display("FAIL range_top got v=%0b e=%0b d=%h want 1 0 cafef00d12345678", data_valid, error, data_out);
        end
    endtask

    task automatic test_back_to_back();
        req(RAM_STORE, RAM_LONG, 20, 64'h0BAD_F00D);
        req(RAM_STORE, RAM_LONG, 16, 64'hDEAD_BEEF);
        req(RAM_LOAD, RAM_LONG, 16, 64'h0);
        total++;
        if ({data_valid, data_out} !== {1'b1, 64'hDEADBEEF}) begin
            bad++;
            $display("FAIL raw_ld16 got v=%0b d=%h want 1 deadbeef", data_valid, data_out);
        end
        req(RAM_LOAD, RAM_LONG, 16, 64'h0);
        req(RAM_LOAD, RAM_LONG, 20, 64'h0);
        total++;
        if ({data_valid, data_out} !== {1'b1, 64'h0BADF00D}) begin
            bad++;
            $display("FAIL b2b_ld20 got v=%0b d=%h want 1 0badf00d", data_valid, data_out);
        end
    endtask

    task automatic test_reset_midload();
        req(RAM_LOAD, RAM_LONG, 16, 64'h0);
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if ({data_valid, error, data_out} !== {2'b00, 64'h0}) begin
            bad++;
            $display("FAIL rst_async got v=%0b e=%0b d=%h want 0 0 0", data_valid, error, data_out);
        end
        op = RAM_LOAD; size = RAM_LONG; addr = 0;
        @(posedge clk);
        #1;
        op = RAM_NOP;
        total++;
        if ({data_valid, data_out} !== {1'b0, 64'h0}) begin
            bad++;
            $display("FAIL rst_hold got v=%0b d=%h want 0 0", data_valid, data_out);
        end
        rst_n = 1'b1;
        req(RAM_LOAD, RAM_LONG, 32, 64'h0);
        total++;
        if ({data_valid, error, data_out} !== {2'b10, 64'h68656C6C}) begin
            bad++;
            $display("FAIL rst_keep got v=%0b e=%0b d=%h want 1 0 68656c6c", data_valid, error, data_out);
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [6:0]  s;
        logic [31:0] a;
        logic [6:0]  sizes [5];
        int          r;
        sizes[0] = RAM_BYTE; sizes[1] = RAM_WORD; sizes[2] = RAM_LONG;
        sizes[3] = RAM_QUAD; sizes[4] = 7'd24;
        for (int q = 0; q < 32; q++) req(RAM_STORE, RAM_QUAD, q * 8, {$urandom, $urandom});
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            o = (r < 2) ? RAM_NOP : (r < 6) ? RAM_LOAD : (r < 9) ? RAM_STORE : RAM_BAD;
            s = sizes[$urandom_range(0, 4)];
            a = ($urandom_range(0, 9) == 0) ? DEPTH * 8 + $urandom_range(0, 63)
                                            : $urandom_range(0, 255);
            req(o, s, a, {$urandom, $urandom});
            total++;
            if ({data_valid, error} !== {exp_valid, exp_err}) begin
                bad++;
                $display("FAIL rnd_flags n=%0d op=%0d sz=%0d a=%0h got v=%0b e=%0b want %0b %0b",
                         n, o, s, a, data_valid, error, exp_valid, exp_err);
            end
            if (exp_known) begin
                total++;
                if (data_out !== exp_out) begin
                    bad++;
                    $display("FAIL rnd_data n=%0d op=%0d sz=%0d a=%0h got %h want %h",
                             n, o, s, a, data_out, exp_out);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_loader();
        test_byte_lanes();
        test_alignment();
        test_range();
        test_back_to_back();
        test_reset_midload();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
